// File: rtl/i2s_target.sv
// I2S target (codec side): receives one sample per channel slot on sdin and transmits
// tx_data0/tx_data1 on sdout, all sampled into the clk domain through synchronizers.
module i2s_target #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SYNC  = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             sdin,
    output logic             sdout,
    output logic [WIDTH-1:0] rx_data,
    output logic [1:0]       rx_vld,
    output logic [1:0]       tx_ack,
    input  logic [WIDTH-1:0] tx_data0,
    input  logic [WIDTH-1:0] tx_data1,
    output logic             locked,
    output logic             short_err
);

    localparam logic [5:0] WidthCnt = 6'(WIDTH);
    localparam logic [5:0] LastBit  = 6'(WIDTH - 1);
    localparam logic [5:0] CntMax   = 6'd63;

    // Synchronizers and sclk edge detection
    logic [SYNC-1:0] sclk_sync_q;
    logic [SYNC-1:0] lr_sync_q;
    logic [SYNC-1:0] sd_sync_q;
    logic            sclk_prev_q;
    logic            rise_q;
    logic            fall_q;
    logic            sclk_s;
    logic            lr_s;
    logic            sd_s;

    assign sclk_s = sclk_sync_q[SYNC-1];
    assign lr_s   = lr_sync_q[SYNC-1];
    assign sd_s   = sd_sync_q[SYNC-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC-2:0], sclk};
            lr_sync_q   <= {lr_sync_q[SYNC-2:0], lrclk};
            sd_sync_q   <= {sd_sync_q[SYNC-2:0], sdin};
            sclk_prev_q <= sclk_s;
            rise_q      <= sclk_s & ~sclk_prev_q;
            fall_q      <= ~sclk_s & sclk_prev_q;
        end
    end

    // Slot tracking, receive and transmit datapath
    logic             lr_prev_q,   lr_prev_d;
    logic             ch_q,        ch_d;
    logic             locked_q,    locked_d;
    logic [5:0]       bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0] rx_shift_q,  rx_shift_d;
    logic [WIDTH-1:0] rx_data_q,   rx_data_d;
    logic [1:0]       rx_vld_q,    rx_vld_d;
    logic             short_err_q, short_err_d;
    logic [WIDTH-1:0] tx_shift_q,  tx_shift_d;
    logic [1:0]       ack_pend_q,  ack_pend_d;
    logic [1:0]       tx_ack_q,    tx_ack_d;
    logic             sdout_q,     sdout_d;

    always_comb begin
        lr_prev_d   = lr_prev_q;
        ch_d        = ch_q;
        locked_d    = locked_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_vld_d    = 2'b00;
        short_err_d = 1'b0;
        tx_shift_d  = tx_shift_q;
        ack_pend_d  = 2'b00;
        tx_ack_d    = ack_pend_q;
        sdout_d     = sdout_q;

        if (rise_q) begin
            lr_prev_d = lr_s;
            if (lr_s != lr_prev_q) begin
                // Slot boundary: a partial sample in a locked slot is dropped and flagged
                if (locked_q && (bit_cnt_q != 6'd0) && (bit_cnt_q < WidthCnt)) begin
                    short_err_d = 1'b1;
                end
                bit_cnt_d  = 6'd0;
                ch_d       = lr_s;
                locked_d   = 1'b1;
                rx_shift_d = '0;
                tx_shift_d = lr_s ? tx_data1 : tx_data0;
                ack_pend_d = lr_s ? 2'b10 : 2'b01;
            end else begin
                if (bit_cnt_q != CntMax) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
                if (locked_q && (bit_cnt_q < WidthCnt)) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], sd_s};
                    if (bit_cnt_q == LastBit) begin
                        rx_data_d      = {rx_shift_q[WIDTH-2:0], sd_s};
                        rx_vld_d[ch_q] = 1'b1;
                    end
                end
            end
        end

        // Zeros shift in behind the sample, so sdout idles low once WIDTH bits are out
        if (fall_q) begin
            if (locked_q) begin
                sdout_d    = tx_shift_q[WIDTH-1];
                tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            end else begin
                sdout_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lr_prev_q   <= 1'b0;
            ch_q        <= 1'b0;
            locked_q    <= 1'b0;
            bit_cnt_q   <= 6'd0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_vld_q    <= 2'b00;
            short_err_q <= 1'b0;
            tx_shift_q  <= '0;
            ack_pend_q  <= 2'b00;
            tx_ack_q    <= 2'b00;
            sdout_q     <= 1'b0;
        end else begin
            lr_prev_q   <= lr_prev_d;
            ch_q        <= ch_d;
            locked_q    <= locked_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_vld_q    <= rx_vld_d;
            short_err_q <= short_err_d;
            tx_shift_q  <= tx_shift_d;
            ack_pend_q  <= ack_pend_d;
            tx_ack_q    <= tx_ack_d;
            sdout_q     <= sdout_d;
        end
    end

    assign sdout     = sdout_q;
    assign rx_data   = rx_data_q;
    assign rx_vld    = rx_vld_q;
    assign tx_ack    = tx_ack_q;
    assign locked    = locked_q;
    assign short_err = short_err_q;

endmodule

// File: tb/tb_i2s_target.sv
// Scoreboard bench for i2s_target: a bus-master model drives slots, expected strobes are
// queued per slot and popped by a monitor as the DUT presents them.
module tb_i2s_target;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         sclk = 1'b0;
    logic         lrclk = 1'b0;
    logic         sdin = 1'b0;
    logic         sdout;
    logic [W-1:0] rx_data;
    logic [1:0]   rx_vld;
    logic [1:0]   tx_ack;
    logic [W-1:0] tx_data0 = '0;
    logic [W-1:0] tx_data1 = '0;
    logic         locked;
    logic         short_err;

    always #5 clk = ~clk;

    i2s_target #(.WIDTH(W), .SYNC(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sdin      (sdin),
        .sdout     (sdout),
        .rx_data   (rx_data),
        .rx_vld    (rx_vld),
        .tx_ack    (tx_ack),
        .tx_data0  (tx_data0),
        .tx_data1  (tx_data1),
        .locked    (locked),
        .short_err (short_err)
    );

    typedef struct packed {
        logic         ch;
        logic [W-1:0] data;
    } rx_t;

    int          checks = 0;
    int          errors = 0;
    rx_t         rx_q[$];
    logic        ack_q[$];
    logic [31:0] cap_q[$];
    int          short_got = 0;
    int          short_exp = 0;

    // Reference model state of the slot tracker
    logic        m_prev_lr = 1'b0;
    logic        m_locked = 1'b0;
    int          m_cnt = 0;
    bit          cap_armed = 1'b0;
    logic [31:0] cap_acc = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes
    always @(negedge clk) begin
        rx_t e;
        logic a;
        if (rstn) begin
            if (rx_vld != 2'b00) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_vld_unexpected: got %b data %h expected no strobe",
                             rx_vld, rx_data);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_vld_ch", 64'(rx_vld), e.ch ? 64'd2 : 64'd1);
                    check("rx_data", 64'(rx_data), 64'(e.data));
                end
            end
            if (tx_ack != 2'b00) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_ack_unexpected: got %b expected no strobe", tx_ack);
                end else begin
                    a = ack_q.pop_front();
                    check("tx_ack_ch", 64'(tx_ack), a ? 64'd2 : 64'd1);
                end
            end
            if (short_err) short_got++;
        end
    end

    // One channel slot of len sclk periods; stop_at >= 0 ends it right after that fall
    task automatic slot(input logic ch, input logic [W-1:0] word, input int len,
                        input int stop_at);
        logic [W-1:0] txw;
        logic [31:0]  exp;
        logic [31:0]  e;
        bit           bnd;
        rx_t          r;
        bnd = (ch != m_prev_lr);
        if (bnd) begin
            if (m_locked && m_cnt >= 1 && m_cnt <= W - 1) short_exp++;
            m_locked = 1'b1;
            ack_q.push_back(ch);
            if (stop_at < 0 && len - 1 >= W) begin
                r.ch   = ch;
                r.data = word;
                rx_q.push_back(r);
            end
            m_cnt = len - 1;
        end else begin
            m_cnt = (m_cnt + len > 63) ? 63 : m_cnt + len;
        end
        m_prev_lr = ch;
        txw = ch ? tx_data1 : tx_data0;
        exp = '0;
        for (int k = 0; k < len; k++) begin
            exp = {exp[30:0], (bnd && k < W) ? txw[W-1-k] : 1'b0};
        end
        cap_q.push_back(exp);

        for (int i = 0; i < len; i++) begin
            sclk  = 1'b0;
            lrclk = ch;
            sdin  = (i >= 1 && i <= W) ? word[W-i] : 1'b0;
            repeat (8) @(posedge clk);
            #1;
            if (i == stop_at) return;
            sclk = 1'b1;
            cap_acc = {cap_acc[30:0], sdout};
            if (i == 0) begin
                // The boundary rise carries the last bit of the previous slot
                if (cap_armed) begin
                    e = cap_q.pop_front();
                    check("master_capture", 64'(cap_acc), 64'(e));
                end
                cap_acc   = '0;
                cap_armed = 1'b1;
            end
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut(input bit park);
        if (park) begin
            sclk  = 1'b0;
            lrclk = 1'b0;
            sdin  = 1'b0;
            repeat (6) @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        #1;
        check("rst_rx_data", 64'(rx_data), 64'd0);
        check("rst_rx_vld", 64'(rx_vld), 64'd0);
        check("rst_tx_ack", 64'(tx_ack), 64'd0);
        check("rst_short_err", 64'(short_err), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_sdout", 64'(sdout), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn      = 1'b1;
        m_prev_lr = 1'b0;
        m_locked  = 1'b0;
        m_cnt     = 0;
        cap_q.delete();
        cap_armed = 1'b0;
        cap_acc   = '0;
        short_got = 0;
        short_exp = 0;
    endtask

    task automatic end_scenario();
        repeat (20) @(posedge clk);
        #1;
        check("rx_pending", 64'(rx_q.size()), 64'd0);
        check("ack_pending", 64'(ack_q.size()), 64'd0);
        check("short_err_count", 64'(short_got), 64'(short_exp));
        rx_q.delete();
        ack_q.delete();
    endtask

    initial begin
        #1;
        // Full 32-bit slots: receive both channels and loop back transmit words
        reset_dut(1'b0);
        tx_data0 = 24'h800001;
        tx_data1 = 24'h7FFFFE;
        slot(1'b0, 24'h000000, 32, -1);
        slot(1'b1, 24'h0F0F0F, 32, -1);
        slot(1'b0, 24'hA5C3F1, 32, -1);
        slot(1'b1, 24'h123456, 32, -1);
        slot(1'b0, 24'h000000, 32, -1);
        end_scenario();
        check("s1_locked", 64'(locked), 64'd1);

        // 16-bit slots: every locked boundary is short, sdout carries 16 MSBs
        reset_dut(1'b1);
        tx_data0 = 24'hABCDEF;
        tx_data1 = 24'h135799;
        slot(1'b1, 24'h111111, 16, -1);
        slot(1'b0, 24'h222222, 16, -1);
        slot(1'b1, 24'h333333, 16, -1);
        slot(1'b0, 24'h444444, 16, -1);
        slot(1'b1, 24'h555555, 16, -1);
        end_scenario();
        check("s2_short_total", 64'(short_got), 64'd4);

        // Unlocked idle, lock on first lrclk rise, then reset mid ch1 slot
        reset_dut(1'b1);
        tx_data0 = 24'h5A5A5A;
        tx_data1 = 24'hC3C3C3;
        slot(1'b0, 24'hFFFFFF, 32, -1);
        check("idle_locked", 64'(locked), 64'd0);
        check("idle_sdout", 64'(sdout), 64'd0);
        slot(1'b1, 24'h112233, 32, -1);
        check("lock_locked", 64'(locked), 64'd1);
        slot(1'b0, 24'h445566, 32, -1);
        slot(1'b1, 24'h998877, 32, 10);
        reset_dut(1'b0);
        slot(1'b1, 24'h000000, 22, -1);
        slot(1'b0, 24'h778899, 32, -1);
        slot(1'b1, 24'hAABBCC, 32, -1);
        slot(1'b0, 24'h000000, 32, -1);
        end_scenario();
        check("s3_locked", 64'(locked), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule
